btn_event_scheduler: RTL

//   Front-end input controller for the Enigma encryptor's push-buttons. Debounces
//   NUM_BTN raw buttons on msclk and turns each clean press (0->1) into a one-shot

---
 rtl/btn_event_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/btn_event_scheduler.sv
// btn_event_scheduler: debounced push-button press events, round-robin queued for the encryptor core
// Ports:
//   msclk        sample/system clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   btn_raw      raw (already synchronised) button inputs
//   btn_level    debounced button levels
//   evt_valid    FIFO head holds a press event
//   evt_id       button index of the head event
//   evt_ready    consumer accepts the head event this cycle
//   overflow     sticky flag: a press was coalesced and dropped
//   clr_overflow synchronous clear of overflow (a same-edge set wins)
module btn_event_scheduler #(
    parameter int NUM_BTN    = 4,
    parameter int STABLE_CNT = 10,
    parameter int FIFO_DEPTH = 4,
    localparam int IDW       = $clog2(NUM_BTN)
) (
    input  logic               msclk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    output logic [IDW-1:0]     evt_id,
    input  logic               evt_ready,
    output logic               overflow,
    input  logic               clr_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [STABLE_CNT-1:0] r_sr [NUM_BTN];
    logic [NUM_BTN-1:0]    r_level, r_pend;
    logic [IDW-1:0]        r_rr;
    logic [IDW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr, r_rd;
    logic [CW-1:0]         r_cnt;
    logic                  r_ovf;

    logic [NUM_BTN-1:0]    w_level_nxt, w_press, w_gnt_oh;
    logic [IDW-1:0]        w_gnt;
    logic                  w_found, w_push, w_pop;

    // A level only changes once the whole shift window agrees.
    always_comb begin
        w_level_nxt = r_level;
        for (int i = 0; i < NUM_BTN; i++)
            w_level_nxt[i] = &r_sr[i] ? 1'b1 : ~|r_sr[i] ? 1'b0 : r_level[i];
    end

    assign w_press = w_level_nxt & ~r_level;

    // Round-robin search starting at r_rr; first pending index wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            if (!w_found && r_pend[(int'(r_rr) + k) % NUM_BTN]) begin
                w_found = 1'b1;
                w_gnt   = IDW'((int'(r_rr) + k) % NUM_BTN);
            end
        end
    end

    // Uses the pre-edge count: a same-cycle pop does not make room for this push.
    assign w_push   = w_found && (r_cnt < CW'(FIFO_DEPTH));
    assign w_pop    = evt_valid && evt_ready;
    assign w_gnt_oh = w_push ? (NUM_BTN'(1) << w_gnt) : '0;

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) r_sr[i] <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) r_mem[j] <= '0;
            r_level <= '0;
            r_pend  <= '0;
            r_rr    <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) r_sr[i] <= {r_sr[i][STABLE_CNT-2:0], btn_raw[i]};
            r_level <= w_level_nxt;
            // A fresh press re-arms a button whose old request is granted this edge.
            r_pend  <= (r_pend & ~w_gnt_oh) | w_press;
            if (w_push) begin
                r_mem[r_wr] <= w_gnt;
                r_wr        <= r_wr + PW'(1);
                r_rr        <= (w_gnt == IDW'(NUM_BTN - 1)) ? '0 : w_gnt + IDW'(1);
            end
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_ovf <= |(w_press & r_pend & ~w_gnt_oh) | (r_ovf & ~clr_overflow);
        end
    end

    assign btn_level = r_level;
    assign evt_valid = r_cnt != '0;
    assign evt_id    = r_mem[r_rd];
    assign overflow  = r_ovf;
endmodule
